// File: rtl/regfile_scan_display.sv
// regfile_scan_display
// Register file with one write port and one registered read port. A built-in
// multiplexed 7-segment scanner drives a common-anode style display. Mode 0
// shows reg[re_addr] as hex nibbles, one per digit. Mode 1 shows the low
// nibble of every register, one register per digit.
// sel and digit are registered from the same next-index value, so a digit's
// segments are never driven together with another digit's select.

module regfile_scan_display #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 2,
  parameter int NUM_DIG  = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] re_addr,
  input  logic              mode,
  output logic [DATA_W-1:0] rd_data,
  output logic [7:0]        digit,
  output logic [NUM_DIG-1:0] sel
);

  // Counter widths never drop below one bit, so a divider or digit count of 1
  // still gets a legal (constant) register.
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIG - 1);

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_ZERO  = 8'hC0;

  // Register array and its next-state image
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  // Scan prescaler and digit index
  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic             tick;

  // Registered outputs
  logic [DATA_W-1:0]  rd_data_q;
  logic [DATA_W-1:0]  rd_data_d;
  logic [NUM_DIG-1:0] sel_q;
  logic [NUM_DIG-1:0] sel_d;
  logic [7:0]         digit_q;
  logic [7:0]         digit_d;

  // Read-side helpers
  logic [DATA_W-1:0] rd_word;
  logic [3:0]        nib;
  logic              blank;

  // Hex digit to active-low segments {dp,g,f,e,d,c,b,a}, decimal point off
  function automatic logic [7:0] seg7(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0:    s = 8'hC0;
      4'h1:    s = 8'hF9;
      4'h2:    s = 8'hA4;
      4'h3:    s = 8'hB0;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h92;
      4'h6:    s = 8'h82;
      4'h7:    s = 8'hF8;
      4'h8:    s = 8'h80;
      4'h9:    s = 8'h90;
      4'hA:    s = 8'h88;
      4'hB:    s = 8'h83;
      4'hC:    s = 8'hC6;
      4'hD:    s = 8'hA1;
      4'hE:    s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Write port: addresses at or beyond DEPTH match no register and are dropped
  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (en && (int'(in_addr) == k)) begin
        regs_d[k] = in_data;
      end
    end
  end

  // Read mux on pre-edge contents; an unmapped address reads as zero
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (int'(re_addr) == k) begin
        rd_word = regs_q[k];
      end
    end
    rd_data_d = rd_word;
  end

  // Prescaler wraps at SCAN_DIV-1; the wrap cycle advances the digit index
  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + PRE_W'(1);
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Nibble for the digit about to be selected; mode 1 blanks missing registers
  always_comb begin
    nib   = 4'h0;
    blank = 1'b0;
    if (!mode) begin
      for (int k = 0; k < NUM_DIG; k++) begin
        if (int'(idx_d) == k) begin
          nib = 4'(rd_word >> (4 * k));
        end
      end
    end else begin
      blank = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
        if (int'(idx_d) == k) begin
          blank = 1'b0;
          nib   = 4'(regs_q[k]);
        end
      end
    end
  end

  // Select and segments are derived from the same next index
  always_comb begin
    sel_d   = ~(NUM_DIG'(1) << idx_d);
    digit_d = blank ? SEG_BLANK : seg7(nib);
  end

  // Register file storage, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Scan timing state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      idx_q <= '0;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
    end
  end

  // Output registers; reset shows "0" on digit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      sel_q     <= ~NUM_DIG'(1);
      digit_q   <= SEG_ZERO;
    end else begin
      rd_data_q <= rd_data_d;
      sel_q     <= sel_d;
      digit_q   <= digit_d;
    end
  end

  assign rd_data = rd_data_q;
  assign sel     = sel_q;
  assign digit   = digit_q;

endmodule

// File: tb/tb_regfile_scan_display.sv
// tb_regfile_scan_display
// Two instances share every input: dut A uses DEPTH=4, dut B uses DEPTH=3.
// Both use SCAN_DIV=4 and NUM_DIG=4. The stimulus pushes hand-computed
// expectations, tagged with the current cycle, into a scoreboard queue. A
// monitor on the falling edge pops the expectations and compares them.

module tb_regfile_scan_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  in_addr;
  logic [15:0] in_data;
  logic [1:0]  re_addr;
  logic        mode;

  logic [15:0] a_rd;
  logic [7:0]  a_digit;
  logic [3:0]  a_sel;
  logic [15:0] b_rd;
  logic [7:0]  b_digit;
  logic [3:0]  b_sel;

  regfile_scan_display #(
    .DATA_W(16), .DEPTH(4), .ADDR_W(2), .NUM_DIG(4), .SCAN_DIV(4)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .in_addr(in_addr), .in_data(in_data),
    .re_addr(re_addr), .mode(mode), .rd_data(a_rd), .digit(a_digit), .sel(a_sel)
  );

  regfile_scan_display #(
    .DATA_W(16), .DEPTH(3), .ADDR_W(2), .NUM_DIG(4), .SCAN_DIV(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .in_addr(in_addr), .in_data(in_data),
    .re_addr(re_addr), .mode(mode), .rd_data(b_rd), .digit(b_digit), .sel(b_sel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          dut;
    string       name;
    logic [3:0]  sel;
    logic [7:0]  dig;
    logic [15:0] rd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_fail = 0;
  int   n_edge = 0;

  task automatic applyStimulus(input logic we, input logic [1:0] wa, input logic [15:0] wd,
                               input logic [1:0] ra, input logic md);
    en      = we;
    in_addr = wa;
    in_data = wd;
    re_addr = ra;
    mode    = md;
  endtask

  task automatic next_edge(input int cnt);
    repeat (cnt) begin
      @(posedge clk);
      #1;
      n_edge++;
    end
  endtask

  function automatic void push_exp(input string nm, input int dut, input logic [3:0] s,
                                   input logic [7:0] d, input logic [15:0] r);
    exp_t e;
    e.cyc  = cyc;
    e.dut  = dut;
    e.name = nm;
    e.sel  = s;
    e.dig  = d;
    e.rd   = r;
    sb.push_back(e);
  endfunction

  function automatic void both(input string nm, input logic [3:0] s,
                               input logic [7:0] da, input logic [15:0] ra,
                               input logic [7:0] db, input logic [15:0] rb);
    push_exp(nm, 0, s, da, ra);
    push_exp(nm, 1, s, db, rb);
  endfunction

  task automatic checkOutput(input exp_t e);
    logic [3:0]  s;
    logic [7:0]  d;
    logic [15:0] r;
    s = (e.dut == 0) ? a_sel   : b_sel;
    d = (e.dut == 0) ? a_digit : b_digit;
    r = (e.dut == 0) ? a_rd    : b_rd;
    n_vec++;
    if (s !== e.sel) begin
      n_fail++;
      $display("[TB] FAIL %s dut%0d sel: got %b want %b", e.name, e.dut, s, e.sel);
    end
    n_vec++;
    if (d !== e.dig) begin
      n_fail++;
      $display("[TB] FAIL %s dut%0d digit: got %h want %h", e.name, e.dut, d, e.dig);
    end
    n_vec++;
    if (r !== e.rd) begin
      n_fail++;
      $display("[TB] FAIL %s dut%0d rd_data: got %h want %h", e.name, e.dut, r, e.rd);
    end
  endtask

  // Monitor: compare every expectation due at this falling edge
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.cyc < cyc) begin
        n_vec++;
        n_fail++;
        $display("[TB] FAIL %s dut%0d stale expectation: got cycle %0d want %0d",
                 mon_e.name, mon_e.dut, cyc, mon_e.cyc);
      end else begin
        checkOutput(mon_e);
      end
    end
  end

  initial begin
    #200000;
    n_fail++;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 2'd0, 16'h0000, 2'd0, 1'b0);
    next_edge(1);
    both("reset_initial", 4'b1110, 8'hC0, 16'h0000, 8'hC0, 16'h0000);
    @(negedge clk);
    #1;
    rst_n  = 1'b1;
    n_edge = 0;

    // Write A5C3 to reg2 while reading reg2
    applyStimulus(1'b1, 2'd2, 16'hA5C3, 2'd2, 1'b0);
    next_edge(1);
    both("write_edge", 4'b1110, 8'hC0, 16'h0000, 8'hC0, 16'h0000);
    applyStimulus(1'b0, 2'd2, 16'hA5C3, 2'd2, 1'b0);
    next_edge(1);
    both("read_latency", 4'b1110, 8'hB0, 16'hA5C3, 8'hB0, 16'hA5C3);

    // Mode 0 scan of A5C3: 3, C, 5, A
    next_edge(1);
    both("scan_n3", 4'b1110, 8'hB0, 16'hA5C3, 8'hB0, 16'hA5C3);
    next_edge(1);
    both("scan_d1", 4'b1101, 8'hC6, 16'hA5C3, 8'hC6, 16'hA5C3);
    next_edge(4);
    both("scan_d2", 4'b1011, 8'h92, 16'hA5C3, 8'h92, 16'hA5C3);
    next_edge(4);
    both("scan_d3", 4'b0111, 8'h88, 16'hA5C3, 8'h88, 16'hA5C3);
    next_edge(4);
    both("scan_wrap", 4'b1110, 8'hB0, 16'hA5C3, 8'hB0, 16'hA5C3);

    // Write during display of digit 0
    applyStimulus(1'b1, 2'd2, 16'hA5C7, 2'd2, 1'b0);
    next_edge(1);
    both("wr_disp_old", 4'b1110, 8'hB0, 16'hA5C3, 8'hB0, 16'hA5C3);
    applyStimulus(1'b0, 2'd2, 16'hA5C7, 2'd2, 1'b0);
    next_edge(1);
    both("wr_disp_new", 4'b1110, 8'hF8, 16'hA5C7, 8'hF8, 16'hA5C7);

    // Address 3: valid on A, out of range on B
    applyStimulus(1'b1, 2'd3, 16'h12EF, 2'd2, 1'b0);
    next_edge(1);
    both("wr_addr3", 4'b1110, 8'hF8, 16'hA5C7, 8'hF8, 16'hA5C7);
    applyStimulus(1'b0, 2'd3, 16'h12EF, 2'd3, 1'b0);
    next_edge(1);
    both("rd_addr3_d1", 4'b1101, 8'h86, 16'h12EF, 8'hC0, 16'h0000);
    next_edge(4);
    both("rd_addr3_d2", 4'b1011, 8'hA4, 16'h12EF, 8'hC0, 16'h0000);

    // Load regs 0..2 with 1, 2, 3
    applyStimulus(1'b1, 2'd0, 16'h0001, 2'd3, 1'b0);
    next_edge(1);
    applyStimulus(1'b1, 2'd1, 16'h0002, 2'd3, 1'b0);
    next_edge(1);
    applyStimulus(1'b1, 2'd2, 16'h0003, 2'd3, 1'b0);
    next_edge(1);
    applyStimulus(1'b0, 2'd2, 16'h0003, 2'd3, 1'b0);
    next_edge(1);
    both("rd_addr3_d3", 4'b0111, 8'hF9, 16'h12EF, 8'hC0, 16'h0000);

    // Mode toggle while idx=1 and the prescaler is 1
    next_edge(9);
    both("pre_toggle", 4'b1101, 8'h86, 16'h12EF, 8'hC0, 16'h0000);
    applyStimulus(1'b0, 2'd2, 16'h0003, 2'd3, 1'b1);
    next_edge(1);
    both("toggle_d1", 4'b1101, 8'hA4, 16'h12EF, 8'hA4, 16'h0000);
    next_edge(2);
    both("mode1_d2", 4'b1011, 8'hB0, 16'h12EF, 8'hB0, 16'h0000);
    next_edge(4);
    both("mode1_d3", 4'b0111, 8'h8E, 16'h12EF, 8'hFF, 16'h0000);
    next_edge(4);
    both("mode1_d0", 4'b1110, 8'hF9, 16'h12EF, 8'hF9, 16'h0000);
    next_edge(8);
    both("mode1_d2b", 4'b1011, 8'hB0, 16'h12EF, 8'hB0, 16'h0000);

    // Asynchronous reset pulse mid-scan at idx=2
    next_edge(1);
    rst_n = 1'b0;
    #1;
    both("reset_mid", 4'b1110, 8'hC0, 16'h0000, 8'hC0, 16'h0000);
    @(negedge clk);
    #1;
    rst_n  = 1'b1;
    n_edge = 0;
    next_edge(3);
    both("post_rst_n3", 4'b1110, 8'hC0, 16'h0000, 8'hC0, 16'h0000);
    next_edge(1);
    both("post_rst_n4", 4'b1101, 8'hC0, 16'h0000, 8'hC0, 16'h0000);
    next_edge(8);
    both("post_rst_d3", 4'b0111, 8'hC0, 16'h0000, 8'hFF, 16'h0000);

    next_edge(1);
    @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_vec++;
      n_fail++;
      $display("[TB] FAIL %s dut%0d unchecked: got none want cycle %0d",
               mon_e.name, mon_e.dut, mon_e.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
